// File: rtl/sipo_loader_if.sv
// sipo_loader_if: bundles the serial framing inputs and the parallel word
// outputs of sipo_loader.
//   en    - clock enable / stall (master -> slave)
//   start - frame start request     (master -> slave)
//   sin   - serial data bit         (master -> slave)
//   out   - last completed word     (slave -> master)
//   valid - one-cycle "out updated" (slave -> master)
//   busy  - frame in progress       (slave -> master)
interface sipo_loader_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             start;
    logic             sin;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             busy;

    modport master (
        output en, start, sin,
        input  out, valid, busy
    );

    modport slave (
        input  en, start, sin,
        output out, valid, busy
    );
endinterface

// File: rtl/sipo_loader.sv
// sipo_loader: serial-in, parallel-out word assembler.
// Samples a framed serial stream into a WIDTH-bit word and presents it on
// bus.out with a one-cycle bus.valid pulse (drives a downstream register's
// data/enable). bus.en low freezes everything except valid.
//   clk - rising-edge clock
//   rst - synchronous active-high reset, overrides all other inputs
//   bus - sipo_loader_if.slave (en, start, sin in; out, valid, busy out)
module sipo_loader #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    sipo_loader_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sr_next;

    // State register (holds FSM state and datapath registers).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Shift register with the current bit already inserted; used both for the
    // running register and for the completed word so the last bit is included.
    always_comb begin
        if (MSB_FIRST) sr_next = {sr_q[WIDTH-2:0], bus.sin};
        else           sr_next = {bus.sin, sr_q[WIDTH-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        out_d   = out_q;
        valid_d = 1'b0;     // valid clears on every non-completing edge, even with en low
        if (bus.en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_d   = '0;
                        sr_d    = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d = sr_next;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        out_d   = sr_next;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        bus.out   = out_q;
        bus.valid = valid_q;
        bus.busy  = (state_q == SHIFT);
    end
endmodule

// File: tb/tb_sipo_loader.sv
// tb_sipo_loader: directed bench for sipo_loader. Two instances (MSB-first and
// LSB-first) receive identical stimulus; each step checks the packed vector
// {out_msb, out_lsb, valid_msb, valid_lsb, busy_msb, busy_lsb} after an edge.
module tb_sipo_loader;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sipo_loader_if #(.WIDTH(4)) ifm ();
    sipo_loader_if #(.WIDTH(4)) ifl ();

    assign ifl.en    = ifm.en;
    assign ifl.start = ifm.start;
    assign ifl.sin   = ifm.sin;

    sipo_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(ifm));
    sipo_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(ifl));

    logic [11:0] obs;
    assign obs = {ifm.out, ifl.out, ifm.valid, ifl.valid, ifm.busy, ifl.busy};

    // stimulus word: {rst, en, start, sin}

    task automatic test_reset();
        logic [3:0]  st [4] = '{4'b1110, 4'b1110, 4'b0100, 4'b0101};
        logic [11:0] ex [4] = '{12'h000, 12'h000, 12'h000, 12'h000};
        for (int i = 0; i < 4; i++) begin
            {rst, ifm.en, ifm.start, ifm.sin} = st[i];
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL reset step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_frame();
        logic [3:0]  st [6] = '{4'b0110, 4'b0101, 4'b0100, 4'b0101, 4'b0101, 4'b0100};
        logic [11:0] ex [6] = '{{8'h00, 4'b0011}, {8'h00, 4'b0011}, {8'h00, 4'b0011},
                                {8'h00, 4'b0011}, {4'b1011, 4'b1101, 4'b1100},
                                {4'b1011, 4'b1101, 4'b0000}};
        for (int i = 0; i < 6; i++) begin
            {rst, ifm.en, ifm.start, ifm.sin} = st[i];
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL frame step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]  st [8] = '{4'b0110, 4'b0101, 4'b0100, 4'b0011,
                                4'b0010, 4'b0101, 4'b0101, 4'b0100};
        logic [11:0] ex [8];
        for (int i = 0; i < 6; i++) ex[i] = {4'b1011, 4'b1101, 4'b0011};
        ex[6] = {4'b1011, 4'b1101, 4'b1100};
        ex[7] = {4'b1011, 4'b1101, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            {rst, ifm.en, ifm.start, ifm.sin} = st[i];
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL stall step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_ignored_start_and_reset();
        logic [3:0]  st [17] = '{4'b0110, 4'b0100, 4'b0111, 4'b0110, 4'b0100, 4'b0100,
                                 4'b0110, 4'b0101, 4'b0100, 4'b1110, 4'b0101,
                                 4'b0110, 4'b0100, 4'b0101, 4'b0101, 4'b0100, 4'b0100};
        logic [11:0] ex [17] = '{{4'b1011, 4'b1101, 4'b0011}, {4'b1011, 4'b1101, 4'b0011},
                                 {4'b1011, 4'b1101, 4'b0011}, {4'b1011, 4'b1101, 4'b0011},
                                 {4'b0100, 4'b0010, 4'b1100}, {4'b0100, 4'b0010, 4'b0000},
                                 {4'b0100, 4'b0010, 4'b0011}, {4'b0100, 4'b0010, 4'b0011},
                                 {4'b0100, 4'b0010, 4'b0011}, 12'h000, 12'h000,
                                 {8'h00, 4'b0011}, {8'h00, 4'b0011}, {8'h00, 4'b0011},
                                 {8'h00, 4'b0011}, {4'b0110, 4'b0110, 4'b1100},
                                 {4'b0110, 4'b0110, 4'b0000}};
        for (int i = 0; i < 17; i++) begin
            {rst, ifm.en, ifm.start, ifm.sin} = st[i];
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL start/reset step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st [11] = '{4'b0110, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0110,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0100};
        logic [11:0] ex [11] = '{{4'b0110, 4'b0110, 4'b0011}, {4'b0110, 4'b0110, 4'b0011},
                                 {4'b0110, 4'b0110, 4'b0011}, {4'b0110, 4'b0110, 4'b0011},
                                 {4'b1111, 4'b1111, 4'b1100}, {4'b1111, 4'b1111, 4'b0011},
                                 {4'b1111, 4'b1111, 4'b0011}, {4'b1111, 4'b1111, 4'b0011},
                                 {4'b1111, 4'b1111, 4'b0011}, {4'b0001, 4'b1000, 4'b1100},
                                 {4'b0001, 4'b1000, 4'b0000}};
        for (int i = 0; i < 11; i++) begin
            {rst, ifm.en, ifm.start, ifm.sin} = st[i];
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL back-to-back step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        ifm.en    = 1'b1;
        ifm.start = 1'b1;
        ifm.sin   = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_ignored_start_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
